// File: rtl/race_pkg.sv
// Shared state encoding and default frame constants for the racing game sequencer.
package race_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        CNTDN  = 3'd1,
        RUN    = 3'd2,
        PAUSED = 3'd3,
        CRASH  = 3'd4,
        OVER   = 3'd5
    } game_state_t;

    localparam int unsigned DEF_FRAMES_PER_SEC = 60;
    localparam int unsigned DEF_SPEEDUP_FRAMES = 600;
    localparam int unsigned DEF_CRASH_FRAMES   = 90;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_rise_det.sv
// Registered rising-edge detector; history resets high so a button held through reset gives no edge.
module btn_rise_det (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic btn_q;

    always_ff @(posedge clk) begin
        if (reset) btn_q <= 1'b1;
        else       btn_q <= btn;
    end

    assign rise = btn & ~btn_q;

endmodule

// File: rtl/race_game_ctrl.sv
// Racing game sequencer: state machine, collision latch, score/speed and optional lives.
// Optional feature: define RACE_LIVES_EN for multi-life play.
module race_game_ctrl
    import race_pkg::*;
#(
    parameter int unsigned FRAMES_PER_SEC = DEF_FRAMES_PER_SEC,
    parameter int unsigned SPEEDUP_FRAMES = DEF_SPEEDUP_FRAMES,
    parameter int unsigned MAX_SPEED      = 7,
    parameter int unsigned CRASH_FRAMES   = DEF_CRASH_FRAMES,
    parameter int unsigned SCORE_W        = 14,
    parameter int unsigned START_LIVES    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               refresh_tick,
    input  logic               start_btn,
    input  logic               pause_btn,
    input  logic               video_on,
    input  logic               car_on,
    input  logic               obstacle_on,
    output logic               car_reset,
    output logic               car_pause,
    output logic [2:0]         game_state,
    output logic [1:0]         countdown,
    output logic [2:0]         speed,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         lives
);

    localparam int unsigned FC_W = $clog2(max3(FRAMES_PER_SEC, SPEEDUP_FRAMES, CRASH_FRAMES) + 1);

    game_state_t        state, state_n;
    logic [FC_W-1:0]    frame_cnt, frame_cnt_n;
    logic [1:0]         countdown_n;
    logic [2:0]         speed_n;
    logic [SCORE_W-1:0] score_n;
    logic [SCORE_W:0]   score_sum;
    logic               car_reset_n, car_pause_n;
    logic               coll, coll_n;
    logic               start_rise, pause_rise;

    btn_rise_det u_start_det (.clk(clk), .reset(reset), .btn(start_btn), .rise(start_rise));
    btn_rise_det u_pause_det (.clk(clk), .reset(reset), .btn(pause_btn), .rise(pause_rise));

`ifdef RACE_LIVES_EN
    logic [1:0] lives_r, lives_n;
    assign lives = lives_r;
`else
    assign lives = 2'd1;
`endif

    assign game_state = state;
    assign score_sum  = {1'b0, score} + (SCORE_W+1)'(speed);

    always_comb begin
        state_n     = state;
        frame_cnt_n = frame_cnt;
        countdown_n = countdown;
        speed_n     = speed;
        score_n     = score;
        car_reset_n = 1'b0;
`ifdef RACE_LIVES_EN
        lives_n     = lives_r;
`endif
        case (state)
            IDLE: if (start_rise) begin
                state_n     = CNTDN;
                car_reset_n = 1'b1;
                score_n     = '0;
                speed_n     = 3'd1;
                countdown_n = 2'd3;
                frame_cnt_n = '0;
`ifdef RACE_LIVES_EN
                lives_n     = 2'(START_LIVES);
`endif
            end
            CNTDN: if (refresh_tick) begin
                if (frame_cnt == FC_W'(FRAMES_PER_SEC - 1)) begin
                    frame_cnt_n = '0;
                    if (countdown == 2'd1) begin
                        state_n     = RUN;
                        countdown_n = 2'd0;
                    end else begin
                        countdown_n = countdown - 2'd1;
                    end
                end else begin
                    frame_cnt_n = frame_cnt + FC_W'(1);
                end
            end
            RUN: begin
                // A crash on this tick takes priority over any pause edge arriving with it
                if (refresh_tick && coll) begin
                    state_n     = CRASH;
                    frame_cnt_n = '0;
                end else begin
                    if (refresh_tick) begin
                        score_n = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                        if (frame_cnt == FC_W'(SPEEDUP_FRAMES - 1)) begin
                            frame_cnt_n = '0;
                            if (speed != 3'(MAX_SPEED)) speed_n = speed + 3'd1;
                        end else begin
                            frame_cnt_n = frame_cnt + FC_W'(1);
                        end
                    end
                    if (pause_rise) state_n = PAUSED;
                end
            end
            PAUSED: if (pause_rise) state_n = RUN;
            CRASH: if (refresh_tick) begin
                if (frame_cnt == FC_W'(CRASH_FRAMES - 1)) begin
                    frame_cnt_n = '0;
`ifdef RACE_LIVES_EN
                    if (lives_r > 2'd1) begin
                        lives_n     = lives_r - 2'd1;
                        state_n     = CNTDN;
                        car_reset_n = 1'b1;
                        countdown_n = 2'd3;
                    end else begin
                        lives_n = 2'd0;
                        state_n = OVER;
                    end
`else
                    state_n = OVER;
`endif
                end else begin
                    frame_cnt_n = frame_cnt + FC_W'(1);
                end
            end
            OVER: if (start_rise) state_n = IDLE;
            default: state_n = IDLE;
        endcase

        coll_n = refresh_tick ? 1'b0 : (coll | (video_on & car_on & obstacle_on));
        if (state_n != state) coll_n = 1'b0;
        car_pause_n = (state_n != RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            frame_cnt <= '0;
            countdown <= 2'd0;
            speed     <= 3'd1;
            score     <= '0;
            car_reset <= 1'b0;
            car_pause <= 1'b1;
            coll      <= 1'b0;
`ifdef RACE_LIVES_EN
            lives_r   <= 2'(START_LIVES);
`endif
        end else begin
            state     <= state_n;
            frame_cnt <= frame_cnt_n;
            countdown <= countdown_n;
            speed     <= speed_n;
            score     <= score_n;
            car_reset <= car_reset_n;
            car_pause <= car_pause_n;
            coll      <= coll_n;
`ifdef RACE_LIVES_EN
            lives_r   <= lives_n;
`endif
        end
    end

endmodule

// File: tb/tb_race_game_ctrl.sv
// Directed bench for race_game_ctrl (default build, lives feature disabled) with shortened frame constants.
module tb_race_game_ctrl;

    localparam int unsigned FPS = 4;
    localparam int unsigned SPD = 8;
    localparam int unsigned MAXS = 7;
    localparam int unsigned CF  = 5;
    localparam int unsigned SW  = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          refresh_tick = 1'b0;
    logic          start_btn = 1'b0;
    logic          pause_btn = 1'b0;
    logic          video_on = 1'b0;
    logic          car_on = 1'b0;
    logic          obstacle_on = 1'b0;
    logic          car_reset, car_pause;
    logic [2:0]    game_state;
    logic [1:0]    countdown;
    logic [2:0]    speed;
    logic [SW-1:0] score;
    logic [1:0]    lives;

    int unsigned n_checks = 0;
    int unsigned n_bad    = 0;

    race_game_ctrl #(
        .FRAMES_PER_SEC(FPS),
        .SPEEDUP_FRAMES(SPD),
        .MAX_SPEED(MAXS),
        .CRASH_FRAMES(CF),
        .SCORE_W(SW),
        .START_LIVES(3)
    ) dut (
        .clk(clk), .reset(reset), .refresh_tick(refresh_tick),
        .start_btn(start_btn), .pause_btn(pause_btn),
        .video_on(video_on), .car_on(car_on), .obstacle_on(obstacle_on),
        .car_reset(car_reset), .car_pause(car_pause), .game_state(game_state),
        .countdown(countdown), .speed(speed), .score(score), .lives(lives)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        refresh_tick = 1'b1;
        step();
        refresh_tick = 1'b0;
        step();
    endtask

    task automatic start_edge();
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
    endtask

    task automatic pause_edge();
        pause_btn = 1'b1;
        step();
        pause_btn = 1'b0;
    endtask

    task automatic hit_pixel(input logic vis);
        video_on = vis; car_on = 1'b1; obstacle_on = 1'b1;
        step();
        video_on = 1'b0; car_on = 1'b0; obstacle_on = 1'b0;
        step();
    endtask

    task automatic new_game();
        start_edge();
        check("start_state", game_state, 1);
        check("start_car_reset", car_reset, 1);
        check("start_countdown", countdown, 3);
        check("start_score", score, 0);
        check("start_speed", speed, 1);
        step();
        check("car_reset_pulse", car_reset, 0);
        for (int i = 1; i <= 3 * FPS; i++) begin
            tick();
            check("countdown", countdown, (i >= 12) ? 0 : 3 - i / 4);
        end
        check("run_state", game_state, 2);
        check("run_car_pause", car_pause, 0);
    endtask

    task automatic crash_out();
        for (int i = 1; i < CF; i++) tick();
        check("crash_hold", game_state, 4);
        tick();
        check("over_state", game_state, 5);
        check("over_lives", lives, 1);
    endtask

    initial begin
        int unsigned exp_score, exp_speed, fc;

        // start held through reset release must not register an edge
        start_btn = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_state", game_state, 0);
        check("rst_car_pause", car_pause, 1);
        check("rst_car_reset", car_reset, 0);
        check("rst_countdown", countdown, 0);
        check("rst_speed", speed, 1);
        check("rst_score", score, 0);
        check("rst_lives", lives, 1);
        repeat (3) step();
        check("held_start_idle", game_state, 0);
        start_btn = 1'b0;
        step();

        // game 1: basic scoring, speedup, pause, collision
        new_game();
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 7) check("score_t7", score, 7);
            if (i == 8) begin
                check("score_t8", score, 8);
                check("speed_t8", speed, 2);
            end
        end
        check("score_t10", score, 12);
        hit_pixel(1'b0);
        tick();
        check("novis_state", game_state, 2);
        check("novis_score", score, 14);
        pause_edge();
        check("pause_state", game_state, 3);
        check("pause_car_pause", car_pause, 1);
        repeat (3) tick();
        check("pause_score", score, 14);
        start_edge();
        check("pause_start_ign", game_state, 3);
        pause_edge();
        check("resume_state", game_state, 2);
        check("resume_car_pause", car_pause, 0);
        hit_pixel(1'b1);
        check("latched_still_run", game_state, 2);
        tick();
        check("crash_state", game_state, 4);
        check("crash_score", score, 14);
        check("crash_car_pause", car_pause, 1);
        crash_out();
        check("over_score", score, 14);
        start_edge();
        check("over_to_idle", game_state, 0);
        step();

        // game 2: pause edge coinciding with crash tick
        new_game();
        hit_pixel(1'b1);
        pause_btn = 1'b1;
        refresh_tick = 1'b1;
        step();
        pause_btn = 1'b0;
        refresh_tick = 1'b0;
        step();
        check("pause_crash_state", game_state, 4);
        check("pause_crash_score", score, 0);
        crash_out();
        start_edge();
        step();

        // game 3: speed saturation and score saturation
        new_game();
        exp_score = 0; exp_speed = 1; fc = 0;
        for (int i = 1; i <= 70; i++) begin
            tick();
            exp_score = (exp_score + exp_speed > 255) ? 255 : exp_score + exp_speed;
            fc++;
            if (fc == SPD) begin
                fc = 0;
                if (exp_speed < MAXS) exp_speed++;
            end
            check("run_score", score, exp_score);
            check("run_speed", speed, exp_speed);
        end
        check("sat_score", score, 255);
        check("max_speed", speed, 7);

        // reset mid-game
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_state", game_state, 0);
        check("midrst_score", score, 0);
        check("midrst_speed", speed, 1);
        check("midrst_car_pause", car_pause, 1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
